instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/instruction_fetch_pkg.sv | 22 ++
 rtl/fetch_hold_buffer.sv | 36 +++
 rtl/instruction_fetch.sv | 116 +++++++++++
 tb/tb_instruction_fetch.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_fetch_pkg.sv
// Shared pipeline definitions for the instruction fetch stage.
package instruction_fetch_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 32;

    localparam logic [INSTR_W-1:0] NOP_INSTR_DEFAULT = 32'h0000_0013;
    localparam logic [ADDR_W-1:0]  RESET_PC_DEFAULT  = 32'h0000_0000;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } fetch_state_t;

    // Fetch addresses are always word aligned; the low two bits are dropped.
    function automatic logic [ADDR_W-1:0] align_word(input logic [ADDR_W-1:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_hold_buffer.sv
// One-entry parking slot for a fetched instruction and its address while
// decode is stalled.
module fetch_hold_buffer
    import instruction_fetch_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               clear,
    input  logic [INSTR_W-1:0] load_instr,
    input  logic [ADDR_W-1:0]  load_pc,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  pc,
    output logic               full
);

    // Occupancy flag; clear wins so a redirect always empties the slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full <= 1'b0;
        end else if (clear) begin
            full <= 1'b0;
        end else if (load) begin
            full <= 1'b1;
        end
    end

    // Payload needs no reset: it is only consumed while full is set.
    always_ff @(posedge clk) begin
        if (load) begin
            instr <= load_instr;
            pc    <= load_pc;
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: drives the instruction memory, tracks the pc,
// and fills the IF/ID register with instructions or bubbles.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0]  RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_target,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_valid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instr_out,
    output logic [ADDR_W-1:0]  pc_out,
    output logic               valid_out
);

    fetch_state_t       state;
    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W-1:0]  pc_next;
    logic [ADDR_W-1:0]  target;
    logic               hold_load;
    logic               hold_clear;
    logic               hold_full;
    logic [INSTR_W-1:0] hold_instr;
    logic [ADDR_W-1:0]  hold_pc;

    // Modulo-2^32 increment gives the 0xFFFFFFFC -> 0 wrap for free.
    assign pc_next = pc + 32'd4;
    assign target  = align_word(branch_target);

    // A request is open exactly while in FETCH; the address is the pc register.
    assign imem_req  = (state == FETCH);
    assign imem_addr = pc;

    // Park a response that arrives while decode is stalled; drop it on
    // redirect or once decode takes it.
    assign hold_load  = (state == FETCH) && imem_valid && stall && !branch_taken;
    assign hold_clear = branch_taken || ((state == HOLD) && !stall);

    fetch_hold_buffer u_hold (
        .clk        (clk),
        .rst        (rst),
        .load       (hold_load),
        .clear      (hold_clear),
        .load_instr (imem_rdata),
        .load_pc    (pc),
        .instr      (hold_instr),
        .pc         (hold_pc),
        .full       (hold_full)
    );

    // Fetch FSM with pc and IF/ID register; a redirect overrides everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= BOOT;
            pc        <= RESET_PC;
            instr_out <= NOP_INSTR;
            pc_out    <= '0;
            valid_out <= 1'b0;
        end else if (branch_taken) begin
            pc        <= target;
            instr_out <= NOP_INSTR;
            valid_out <= 1'b0;
            // A response still in flight must be swallowed before refetching.
            if (((state == FETCH) || (state == DRAIN)) && !imem_valid) begin
                state <= DRAIN;
            end else begin
                state <= FETCH;
            end
        end else begin
            case (state)
                BOOT: begin
                    state <= FETCH;
                end
                FETCH: begin
                    if (imem_valid) begin
                        pc <= pc_next;
                        if (stall) begin
                            state <= HOLD;
                        end else begin
                            instr_out <= imem_rdata;
                            pc_out    <= pc;
                            valid_out <= 1'b1;
                        end
                    end else if (!stall) begin
                        instr_out <= NOP_INSTR;
                        valid_out <= 1'b0;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        instr_out <= hold_instr;
                        pc_out    <= hold_pc;
                        valid_out <= hold_full;
                        state     <= FETCH;
                    end
                end
                DRAIN: begin
                    if (imem_valid) begin
                        state <= FETCH;
                    end
                end
                default: begin
                    state <= BOOT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed cycle table, reset corner case,
// and a randomized run against a program-order scoreboard.
module tb_instruction_fetch;
    import instruction_fetch_pkg::*;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_rdata;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic        valid_out;

    int n_vec = 0;
    int n_err = 0;

    instruction_fetch dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_valid    (imem_valid),
        .imem_rdata    (imem_rdata),
        .instr_out     (instr_out),
        .pc_out        (pc_out),
        .valid_out     (valid_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        s;
        logic        b;
        logic [31:0] tgt;
        logic        iv;
        logic [31:0] rd;
        logic        rq;
        logic [31:0] addr;
        logic        vo;
        logic [31:0] ins;
        logic [31:0] pco;
    } vec_t;

    vec_t tbl[25];

    function automatic vec_t mk(input logic s, input logic b, input logic [31:0] tgt,
                                input logic iv, input logic [31:0] rd, input logic rq,
                                input logic [31:0] addr, input logic vo,
                                input logic [31:0] ins, input logic [31:0] pco);
        vec_t v;
        v.s = s; v.b = b; v.tgt = tgt; v.iv = iv; v.rd = rd;
        v.rq = rq; v.addr = addr; v.vo = vo; v.ins = ins; v.pco = pco;
        return v;
    endfunction

    // Memory contents for the random run: a fixed scramble of the address.
    function automatic logic [31:0] memword(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic rq, input logic [31:0] ad,
                              input logic vo, input logic [31:0] ins, input logic [31:0] pco);
        check({tag, ".imem_req"},  {31'b0, imem_req},  {31'b0, rq});
        check({tag, ".imem_addr"}, imem_addr, ad);
        check({tag, ".valid_out"}, {31'b0, valid_out}, {31'b0, vo});
        check({tag, ".instr_out"}, instr_out, ins);
        check({tag, ".pc_out"},    pc_out, pco);
    endtask

    task automatic clear_inputs();
        stall = 0; branch_taken = 0; branch_target = '0; imem_valid = 0; imem_rdata = '0;
    endtask

    // Random-phase state
    logic        busy;
    int          cnt;
    logic [31:0] maddr;
    logic [31:0] exp_pc;
    int          consumed;
    logic        prev_ok, prev_stall, prev_br, prev_req, prev_iv, prev_vo;
    logic [31:0] prev_addr, prev_ins, prev_pco;

    initial begin
        // stall, br, target, iv, rdata | req, addr, valid_out, instr_out, pc_out
        tbl[0]  = mk(0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0, NOP,          32'h0);
        tbl[1]  = mk(0, 0, 32'h0,        1, 32'h00A00093, 1, 32'h0,        0, NOP,          32'h0);
        tbl[2]  = mk(0, 0, 32'h0,        1, 32'h11111111, 1, 32'h4,        1, 32'h00A00093, 32'h0);
        tbl[3]  = mk(0, 0, 32'h0,        0, 32'h0,        1, 32'h8,        1, 32'h11111111, 32'h4);
        tbl[4]  = mk(1, 0, 32'h0,        1, 32'h22222222, 1, 32'h8,        0, NOP,          32'h4);
        tbl[5]  = mk(1, 0, 32'h0,        1, 32'hDEADBEEF, 0, 32'hC,        0, NOP,          32'h4);
        tbl[6]  = mk(0, 0, 32'h0,        0, 32'h0,        0, 32'hC,        0, NOP,          32'h4);
        tbl[7]  = mk(0, 0, 32'h0,        0, 32'h0,        1, 32'hC,        1, 32'h22222222, 32'h8);
        tbl[8]  = mk(0, 1, 32'h103,      0, 32'h0,        1, 32'hC,        0, NOP,          32'h8);
        tbl[9]  = mk(0, 0, 32'h0,        1, 32'h33333333, 0, 32'h100,      0, NOP,          32'h8);
        tbl[10] = mk(0, 0, 32'h0,        0, 32'h0,        1, 32'h100,      0, NOP,          32'h8);
        tbl[11] = mk(0, 0, 32'h0,        1, 32'h44444444, 1, 32'h100,      0, NOP,          32'h8);
        tbl[12] = mk(1, 1, 32'h200,      1, 32'h55555555, 1, 32'h104,      1, 32'h44444444, 32'h100);
        tbl[13] = mk(0, 1, 32'hFFFFFFFF, 1, 32'h66666666, 1, 32'h200,      0, NOP,          32'h100);
        tbl[14] = mk(0, 0, 32'h0,        1, 32'h77777777, 1, 32'hFFFFFFFC, 0, NOP,          32'h100);
        tbl[15] = mk(1, 0, 32'h0,        0, 32'h0,        1, 32'h0,        1, 32'h77777777, 32'hFFFFFFFC);
        tbl[16] = mk(1, 0, 32'h0,        1, 32'h88888888, 1, 32'h0,        1, 32'h77777777, 32'hFFFFFFFC);
        tbl[17] = mk(1, 1, 32'h40,       0, 32'h0,        0, 32'h4,        1, 32'h77777777, 32'hFFFFFFFC);
        tbl[18] = mk(0, 0, 32'h0,        0, 32'h0,        1, 32'h40,       0, NOP,          32'hFFFFFFFC);
        tbl[19] = mk(0, 1, 32'h80,       0, 32'h0,        1, 32'h40,       0, NOP,          32'hFFFFFFFC);
        tbl[20] = mk(0, 1, 32'h93,       0, 32'h0,        0, 32'h80,       0, NOP,          32'hFFFFFFFC);
        tbl[21] = mk(0, 0, 32'h0,        1, 32'h99999999, 0, 32'h90,       0, NOP,          32'hFFFFFFFC);
        tbl[22] = mk(0, 0, 32'h0,        1, 32'hAAAAAAAA, 1, 32'h90,       0, NOP,          32'hFFFFFFFC);
        tbl[23] = mk(0, 0, 32'h0,        0, 32'h0,        1, 32'h94,       1, 32'hAAAAAAAA, 32'h90);
        tbl[24] = mk(0, 0, 32'h0,        0, 32'h0,        1, 32'h94,       0, NOP,          32'h90);

        // Reset values while rst is held
        rst = 1;
        clear_inputs();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_outs("reset", 0, 32'h0, 0, NOP, 32'h0);
        @(posedge clk); #1;
        rst = 0;

        // Directed cycle table
        for (int i = 0; i < 25; i++) begin
            stall         = tbl[i].s;
            branch_taken  = tbl[i].b;
            branch_target = tbl[i].tgt;
            imem_valid    = tbl[i].iv;
            imem_rdata    = tbl[i].rd;
            @(negedge clk);
            check_outs($sformatf("row%0d", i), tbl[i].rq, tbl[i].addr, tbl[i].vo, tbl[i].ins, tbl[i].pco);
            @(posedge clk); #1;
        end
        clear_inputs();

        // Reset in the middle of a slow request; the stale reply lands in BOOT
        @(posedge clk); #1;
        rst = 1;
        @(negedge clk);
        check_outs("midreset", 0, 32'h0, 0, NOP, 32'h0);
        @(posedge clk); #1;
        rst = 0;
        imem_valid = 1; imem_rdata = 32'hBADBAD00;
        @(negedge clk);
        check_outs("boot_stale", 0, 32'h0, 0, NOP, 32'h0);
        @(posedge clk); #1;
        imem_valid = 0;
        @(negedge clk);
        check_outs("refetch", 1, 32'h0, 0, NOP, 32'h0);
        @(posedge clk); #1;
        imem_valid = 1; imem_rdata = 32'h01234567;
        @(posedge clk); #1;
        imem_valid = 0;
        @(negedge clk);
        check_outs("restart", 1, 32'h4, 1, 32'h01234567, 32'h0);

        // Randomized run against the program-order scoreboard
        @(posedge clk); #1;
        rst = 1;
        clear_inputs();
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 0;
        busy = 0; cnt = 0; maddr = '0;
        exp_pc = 32'h0; consumed = 0; prev_ok = 0;
        prev_stall = 0; prev_br = 0; prev_req = 0; prev_iv = 0; prev_vo = 0;
        prev_addr = '0; prev_ins = '0; prev_pco = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            imem_valid = 0;
            imem_rdata = $urandom;
            if (busy) begin
                cnt--;
                if (cnt == 0) begin
                    imem_valid = 1;
                    imem_rdata = memword(maddr);
                    busy = 0;
                end
            end else if (imem_req) begin
                busy = 1;
                cnt = $urandom_range(1, 4);
                maddr = imem_addr;
            end
            stall = ($urandom_range(0, 9) < 3);
            branch_taken = ($urandom_range(0, 99) < 6);
            if ($urandom_range(0, 3) == 0) branch_target = 32'hFFFF_FFF0 + $urandom_range(0, 15);
            else branch_target = $urandom_range(0, 4095);

            @(negedge clk);
            if (!valid_out) check("bubble_nop", instr_out, NOP);
            if (prev_ok && prev_stall && !prev_br) begin
                check("stall_hold_vo", {31'b0, valid_out}, {31'b0, prev_vo});
                check("stall_hold_instr", instr_out, prev_ins);
                check("stall_hold_pc", pc_out, prev_pco);
            end
            if (prev_ok && prev_req && !prev_iv && !prev_br) begin
                check("req_stable", {31'b0, imem_req}, 32'd1);
                check("addr_stable", imem_addr, prev_addr);
            end
            if (imem_req) check("addr_align", imem_addr & 32'h3, 32'h0);
            if (valid_out && !stall) begin
                check("seq_pc", pc_out, exp_pc);
                check("seq_instr", instr_out, memword(pc_out));
                exp_pc = pc_out + 32'd4;
                consumed++;
            end
            if (branch_taken) exp_pc = branch_target & 32'hFFFF_FFFC;
            prev_ok = 1; prev_stall = stall; prev_br = branch_taken;
            prev_req = imem_req; prev_iv = imem_valid; prev_addr = imem_addr;
            prev_vo = valid_out; prev_ins = instr_out; prev_pco = pc_out;
            @(posedge clk); #1;
        end
        check("progress", {31'b0, (consumed > 100)}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
